// File: rtl/bnn_config_sequencer.sv
// Configuration front-end for the BNN array: assembles nibble-serial weight/threshold
// records, writes them neuron by neuron, and gates result capture on a complete config.
module bnn_config_sequencer #(
  parameter int unsigned NUM_NEURONS = 20,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned OUT_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_nibble,
  input  logic              in_valid,
  input  logic [OUT_W-1:0]  bnn_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_weight,
  output logic [3:0]        wr_thresh,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic              res_valid,
  output logic [OUT_W-1:0]  res_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        nib_cnt;
  logic [3:0]        w_lo, w_hi;
  logic              wr_en_q, res_valid_q;
  logic              accept, last_nib, last_idx;

  always_comb begin
    accept   = ena && (state == S_LOAD) && cfg_valid && !cfg_start;
    last_nib = (nib_cnt == 2'd2);
    last_idx = (idx == LAST_IDX);
  end

  always_comb begin
    state_nx = state;
    if (ena) begin
      unique case (state)
        S_IDLE: if (cfg_start) state_nx = S_LOAD;
        S_LOAD: begin
          if (cfg_start)                         state_nx = S_LOAD;
          else if (accept && last_nib && last_idx) state_nx = S_DONE;
        end
        S_DONE: if (cfg_start) state_nx = S_LOAD;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // A pending strobe is held across an ena=0 stretch and only masked at the port,
  // so a write or result is delayed rather than lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      nib_cnt     <= '0;
      w_lo        <= '0;
      w_hi        <= '0;
      wr_en_q     <= 1'b0;
      wr_addr     <= '0;
      wr_weight   <= '0;
      wr_thresh   <= '0;
      cfg_error   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data    <= '0;
    end else if (ena) begin
      wr_en_q     <= 1'b0;
      res_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg_start) begin
            idx     <= '0;
            nib_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (cfg_start) begin
            idx     <= '0;
            nib_cnt <= '0;
          end else if (cfg_valid) begin
            unique case (nib_cnt)
              2'd0: begin
                w_lo    <= cfg_nibble;
                nib_cnt <= 2'd1;
              end
              2'd1: begin
                w_hi    <= cfg_nibble;
                nib_cnt <= 2'd2;
              end
              default: begin
                nib_cnt   <= '0;
                wr_en_q   <= 1'b1;
                wr_addr   <= idx;
                wr_weight <= {w_hi, w_lo};
                wr_thresh <= cfg_nibble;
                if (!last_idx) idx <= idx + 1'b1;
              end
            endcase
          end
        end
        S_DONE: begin
          if (cfg_start) begin
            idx       <= '0;
            nib_cnt   <= '0;
            cfg_error <= 1'b0;
          end else if (cfg_valid) begin
            cfg_error <= 1'b1;
          end
          if (in_valid) begin
            res_valid_q <= 1'b1;
            res_data    <= bnn_out;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en     = wr_en_q & ena;
    res_valid = res_valid_q & ena;
    cfg_busy  = (state == S_LOAD);
    cfg_done  = (state == S_DONE);
  end

endmodule

// File: tb/tb_bnn_config_sequencer.sv
// Directed self-checking bench for bnn_config_sequencer: full load, restart,
// inference gating, DONE error, enable freeze and reset abort.
module tb_bnn_config_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b1;
  logic       cfg_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_nibble = '0;
  logic       in_valid = 1'b0;
  logic [3:0] bnn_out = '0;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_weight;
  logic [3:0] wr_thresh;
  logic       cfg_busy, cfg_done, cfg_error, res_valid;
  logic [3:0] res_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bnn_config_sequencer #(.NUM_NEURONS(20), .ADDR_W(5), .OUT_W(4)) dut (
    .clk(clk), .reset(reset), .ena(ena), .cfg_start(cfg_start),
    .cfg_valid(cfg_valid), .cfg_nibble(cfg_nibble), .in_valid(in_valid),
    .bnn_out(bnn_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight(wr_weight),
    .wr_thresh(wr_thresh), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .res_valid(res_valid), .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] n);
    cfg_valid  = 1'b1;
    cfg_nibble = n;
    tick();
    cfg_valid  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".wr_en"},     wr_en, 0);
    check({tag, ".wr_addr"},   wr_addr, 0);
    check({tag, ".wr_weight"}, wr_weight, 0);
    check({tag, ".wr_thresh"}, wr_thresh, 0);
    check({tag, ".busy"},      cfg_busy, 0);
    check({tag, ".done"},      cfg_done, 0);
    check({tag, ".error"},     cfg_error, 0);
    check({tag, ".res_valid"}, res_valid, 0);
    check({tag, ".res_data"},  res_data, 0);
  endtask

  initial begin
    logic [3:0] k4;
    int unsigned pulses;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check_idle_outputs("rst");

    // Inference request in IDLE is dropped
    in_valid = 1'b1; bnn_out = 4'h9;
    tick();
    in_valid = 1'b0;
    check("idle_inf.res_valid", res_valid, 0);

    // 1: full 20-neuron load
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    check("t1.busy", cfg_busy, 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      k4 = k[3:0];
      send_nib(k4);
      send_nib(~k4);
      check("t1.no_wr_mid", wr_en, 0);
      send_nib(4'h5);
      if (wr_en) pulses++;
      check("t1.addr",   wr_addr, k);
      check("t1.weight", wr_weight, {24'h0, ~k4, k4});
      check("t1.thresh", wr_thresh, 5);
      check("t1.done",   cfg_done, (k == 19) ? 1 : 0);
    end
    check("t1.pulses", pulses, 20);
    check("t1.busy_end", cfg_busy, 0);
    tick();
    check("t1.wr_drop",   wr_en, 0);
    check("t1.addr_hold", wr_addr, 19);
    check("t1.done_hold", cfg_done, 1);

    // 3: inference in DONE, including back-to-back requests
    in_valid = 1'b1; bnn_out = 4'hA;
    tick();
    in_valid = 1'b0; bnn_out = 4'h5;
    check("t3.res_valid", res_valid, 1);
    check("t3.res_data",  res_data, 4'hA);
    tick();
    check("t3.pulse_end", res_valid, 0);
    check("t3.data_hold", res_data, 4'hA);
    in_valid = 1'b1; bnn_out = 4'h3;
    tick();
    check("t3.b2b0.valid", res_valid, 1);
    check("t3.b2b0.data",  res_data, 4'h3);
    bnn_out = 4'hC;
    tick();
    in_valid = 1'b0;
    check("t3.b2b1.valid", res_valid, 1);
    check("t3.b2b1.data",  res_data, 4'hC);
    tick();
    check("t3.b2b.end", res_valid, 0);

    // 4: nibble in DONE sets sticky error; cfg_start clears it
    send_nib(4'h9);
    check("t4.error", cfg_error, 1);
    check("t4.no_wr", wr_en, 0);
    check("t4.done",  cfg_done, 1);
    tick(); tick();
    check("t4.sticky", cfg_error, 1);
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    check("t4.err_clr",  cfg_error, 0);
    check("t4.done_clr", cfg_done, 0);
    check("t4.busy",     cfg_busy, 1);

    // Inference in LOAD is dropped and res_data holds
    in_valid = 1'b1; bnn_out = 4'h6;
    tick();
    in_valid = 1'b0;
    check("load_inf.valid", res_valid, 0);
    check("load_inf.data",  res_data, 4'hC);

    // 2: restart mid-neuron (start together with a valid nibble)
    send_nib(4'h1);
    send_nib(4'h2);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_nibble = 4'h3;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    check("t2.no_wr", wr_en, 0);
    check("t2.busy",  cfg_busy, 1);
    send_nib(4'hF);
    send_nib(4'h0);
    check("t2.no_wr_mid", wr_en, 0);
    send_nib(4'h7);
    check("t2.wr_en",  wr_en, 1);
    check("t2.addr",   wr_addr, 0);
    check("t2.weight", wr_weight, 8'h0F);
    check("t2.thresh", wr_thresh, 7);

    // 5: ena low between n1 and n2 freezes everything
    send_nib(4'h2);
    send_nib(4'h3);
    ena = 1'b0; cfg_valid = 1'b1; cfg_nibble = 4'hE; cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5.frz.wr_en", wr_en, 0);
      check("t5.frz.busy",  cfg_busy, 1);
    end
    cfg_valid = 1'b0; ena = 1'b1;
    check("t5.frz.addr", wr_addr, 0);
    send_nib(4'h4);
    check("t5.wr_en",  wr_en, 1);
    check("t5.addr",   wr_addr, 1);
    check("t5.weight", wr_weight, 8'h32);
    check("t5.thresh", wr_thresh, 4);
    tick();
    check("t5.single", wr_en, 0);

    // 6: reset after neuron 5 n1
    for (int k = 2; k < 5; k++) begin
      send_nib(4'h1);
      send_nib(4'h2);
      send_nib(4'h3);
      check("t6.pre.addr", wr_addr, k);
    end
    send_nib(4'hA);
    send_nib(4'hB);
    reset = 1'b1; tick(); reset = 1'b0;
    check_idle_outputs("t6");
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    check("t6.ign.wr_en", wr_en, 0);
    check("t6.ign.busy",  cfg_busy, 0);
    check("t6.ign.addr",  wr_addr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
